// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit-period helper,
// data width and parity helper. Used by both the transmitter and receiver.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Bit period in system clocks, rounded to nearest.
    function automatic int unsigned calc_mod(input int unsigned f, input int unsigned baud);
        return (f + (baud / 32'd2)) / baud;
    endfunction

    // Parity over one data byte; odd = 1 selects odd parity.
    function automatic logic parity8(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Ready/valid byte stream into the UART transmitter.
// master = byte source, slave = transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO. DEPTH must be a power of two, at least 2,
// so that the pointers wrap naturally at their bit width.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              o_full,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign o_full     = (count_q == FULL_CNT);
    assign o_empty    = (count_q == {(AW+1){1'b0}});
    assign o_data_out = mem_q[rd_ptr_q];

    // A push is dropped when full, a pop is dropped when empty.
    assign push_ok_s = i_push && !o_full;
    assign pop_ok_s  = i_pop && !o_empty;

    // Next pointer, count and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = i_data_in;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset flushes all entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, fed by a small FIFO.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned F          = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    uart_tx_if.slave    s_if,
    output logic        o_busy,
    output logic        o_tx
);

    localparam int unsigned MOD = calc_mod(F, BAUD);
    localparam int unsigned CW  = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MOD - 1);

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              bit_end_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_data_s;

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (s_if.i_valid),
        .i_data_in  (s_if.i_data),
        .o_full     (fifo_full_s),
        .i_pop      (pop_s),
        .o_data_out (fifo_data_s),
        .o_empty    (fifo_empty_s)
    );

    assign s_if.o_ready = !fifo_full_s;
    assign o_busy       = (state_q != TX_IDLE) || !fifo_empty_s;
    assign o_tx         = tx_q;
    assign bit_end_s    = (cnt_q == CNT_LAST);

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;

    // Parity of the byte being loaded, captured together with the shift register.
    always_comb begin
        par_d = pop_s ? parity8(fifo_data_s, (PARITY_ODD != 0)) : par_q;
    end

    // Parity bit register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`else
    logic unused_parity_s;
    assign unused_parity_s = (PARITY_ODD != 0);
`endif

    // Frame sequencing: next state, baud count, shift register and next line level.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        pop_s     = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    shreg_d   = fifo_data_s;
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
                    state_d   = TX_START;
                    tx_d      = 1'b0;
                end else begin
                    cnt_d = CNT_ZERO;
                    tx_d  = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = TX_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = par_q;
`else
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = TX_STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            TX_STOP: begin
                if (bit_end_s) begin
                    cnt_d = CNT_ZERO;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty_s) begin
                        pop_s     = 1'b1;
                        shreg_d   = fifo_data_s;
                        bit_idx_d = 3'd0;
                        state_d   = TX_START;
                        tx_d      = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = CNT_ZERO;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Transmitter state registers; reset aborts any frame and idles the line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= TX_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shreg_q   <= {DATA_W{1'b0}};
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at F=1 MHz, BAUD=100 kHz (10 clocks per bit), DEPTH=4.
module tb_uart_tx;

    localparam int unsigned F    = 1000000;
    localparam int unsigned BAUD = 100000;
    localparam int MOD           = 10;
    localparam int PO            = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic tx;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];

    uart_tx_if bus();

    uart_tx #(.F(F), .BAUD(BAUD), .DEPTH(4), .PARITY_ODD(PO)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .s_if   (bus),
        .o_busy (busy),
        .o_tx   (tx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called one sample after o_tx should have fallen; checks every clock of the frame.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [NB-1:0] bits;
        bits        = '1;
        bits[0]     = 1'b0;
        bits[8:1]   = b;
`ifdef UART_TX_PARITY_EN
        bits[9]     = (^b) ^ PO[0];
`endif
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < MOD; c++) begin
                chk($sformatf("%s_bit%0d_clk%0d", tag, k, c), {31'd0, tx}, {31'd0, bits[k]});
                if (c == 0) chk($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
                tick();
            end
        end
    endtask

    task automatic push1(input logic [7:0] b);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] rx;
        rst         = 1'b1;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        repeat (3) tick();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Single byte 0x55 from idle: one cycle latency, then full frame.
        push1(8'h55);
        chk("s1_latency_tx", {31'd0, tx}, 32'd1);
        chk("s1_busy_after_accept", {31'd0, busy}, 32'd1);
        tick();
        check_frame(8'h55, "s1_55");
        chk("s1_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Single byte 0x07 (odd number of ones).
        push1(8'h07);
        tick();
        check_frame(8'h07, "s1_07");
        chk("s1b_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Five bytes back to back, sixth stalls until first frame ends.
        bus.i_data  = 8'h01;
        bus.i_valid = 1'b1;
        tick();
        fork
            begin
                tick();
                for (int i = 1; i <= 6; i++) check_frame(8'(i), $sformatf("s2_f%0d", i));
            end
            begin
                for (int i = 2; i <= 5; i++) begin
                    chk($sformatf("s2_ready%0d", i), {31'd0, bus.o_ready}, 32'd1);
                    bus.i_data = 8'(i);
                    tick();
                end
                chk("s2_full", {31'd0, bus.o_ready}, 32'd0);
                bus.i_data = 8'hEE;
                n = 0;
                while (bus.o_ready !== 1'b1 && n < 200) begin
                    tick();
                    n++;
                    if (n == 50) bus.i_data = 8'hDD;
                end
                chk("s2_stall_cycles", n, 32'd97);
                bus.i_data = 8'h06;
                tick();
                bus.i_valid = 1'b0;
            end
        join
        chk("s2_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Push and pop on the same edge with three bytes queued.
        push1(8'h81);
        fork
            begin
                tick();
                check_frame(8'h81, "s3_f0");
                check_frame(8'h42, "s3_f1");
                check_frame(8'h24, "s3_f2");
                check_frame(8'h18, "s3_f3");
                check_frame(8'hC3, "s3_f4");
            end
            begin
                bus.i_valid = 1'b1;
                bus.i_data  = 8'h42; tick();
                bus.i_data  = 8'h24; tick();
                bus.i_data  = 8'h18; tick();
                bus.i_valid = 1'b0;
                repeat (97) tick();
                chk("s3_ready_before", {31'd0, bus.o_ready}, 32'd1);
                bus.i_data  = 8'hC3;
                bus.i_valid = 1'b1;
                tick();
                bus.i_valid = 1'b0;
                chk("s3_ready_after", {31'd0, bus.o_ready}, 32'd1);
            end
        join
        chk("s3_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Reset in the middle of the data bits of 0xA3 with two bytes queued.
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hA3; tick();
        bus.i_data  = 8'h11; tick();
        bus.i_data  = 8'h22; tick();
        bus.i_valid = 1'b0;
        repeat (40) tick();
        chk("s4_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("s4_rst_tx", {31'd0, tx}, 32'd1);
        chk("s4_rst_busy", {31'd0, busy}, 32'd0);
        chk("s4_rst_ready", {31'd0, bus.o_ready}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            chk($sformatf("s4_quiet_tx%0d", i), {31'd0, tx}, 32'd1);
            chk($sformatf("s4_quiet_busy%0d", i), {31'd0, busy}, 32'd0);
            tick();
        end
        push1(8'h3C);
        chk("s4_latency_tx", {31'd0, tx}, 32'd1);
        tick();
        check_frame(8'h3C, "s4_3c");
        chk("s4_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Loopback of 256 random bytes through a bench-side receiver.
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    logic [7:0] r;
                    r           = 8'($urandom);
                    bus.i_data  = r;
                    bus.i_valid = 1'b1;
                    n = 0;
                    while (bus.o_ready !== 1'b1 && n < 500) begin
                        tick();
                        n++;
                    end
                    exp_q.push_back(r);
                    tick();
                end
                bus.i_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 256; f++) begin
                    int w;
                    w = 0;
                    while (tx !== 1'b0 && w < 500) begin
                        tick();
                        w++;
                    end
                    chk($sformatf("lb_start_seen%0d", f), {31'd0, tx}, 32'd0);
                    if (tx !== 1'b0) break;
                    repeat (MOD / 2) tick();
                    chk($sformatf("lb_start_mid%0d", f), {31'd0, tx}, 32'd0);
                    for (int j = 0; j < 8; j++) begin
                        repeat (MOD) tick();
                        rx[j] = tx;
                    end
`ifdef UART_TX_PARITY_EN
                    repeat (MOD) tick();
                    chk($sformatf("lb_parity%0d", f), {31'd0, tx}, {31'd0, (^rx) ^ PO[0]});
`endif
                    repeat (MOD) tick();
                    chk($sformatf("lb_stop%0d", f), {31'd0, tx}, 32'd1);
                    chk($sformatf("lb_queue%0d", f), {31'd0, (exp_q.size() > 0)}, 32'd1);
                    if (exp_q.size() > 0) chk($sformatf("lb_byte%0d", f), {24'd0, rx}, {24'd0, exp_q.pop_front()});
                end
            end
        join
        repeat (MOD) tick();
        chk("lb_busy_end", {31'd0, busy}, 32'd0);
        chk("lb_idle_tx", {31'd0, tx}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: 8N1 frames, LSB first, baud derived from system clock.
- Small internal FIFO decouples a ready/valid byte source from the serial line.
- Pairs with the design's UART receiver on the same line settings (F, BAUD). Sits between the host byte stream and the top-level TX pin.

Parameters:
- F, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s; bit period MOD = (F+BAUD/2)/BAUD clocks
- DEPTH, 4, FIFO depth in bytes; power of 2, minimum 2
- PARITY_ODD, 0, parity sense when parity is compiled in (0 = even, 1 = odd); ignored otherwise

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- o_busy  out  1  high while the FIFO is non-empty or a frame is in progress
- i_data  in  8  byte to send
- i_valid  in  1  i_data valid
- o_ready  out  1  FIFO can accept; a transfer occurs on an edge where i_valid && o_ready
- o_tx  out  1  serial output, idle high, registered

Behaviour:
- Reset state: o_tx=1, o_ready=1, o_busy=0, FIFO empty, FSM IDLE, baud counter 0. Reset mid-frame aborts the frame: o_tx=1 after the reset edge, FIFO flushed, no partial byte is kept.
- FIFO: o_ready = !full, with full meaning count==DEPTH. Push and pop in the same cycle are both legal; count is unchanged. No push is possible when full. Pointers wrap modulo DEPTH. Data order is strictly FIFO.
- FSM states: IDLE, START, DATA, STOP (PARITY when the option is enabled).
  - IDLE: if FIFO non-empty, pop the head into the shift register, clear the baud counter, go to START, o_tx<=0.
  - START, DATA, PARITY, STOP: each bit lasts exactly MOD clocks. Baud counter counts 0..MOD-1; bit_end = (counter==MOD-1).
  - DATA: o_tx = shreg[0]; shift right on bit_end. Bit index 0..7; after bit 7 go to STOP (or PARITY).
  - STOP: o_tx=1. On bit_end, if FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Latency: byte accepted on edge N into an empty, idle block -> o_tx falls after edge N+1.
- Frame length: 10*MOD clocks (11*MOD with parity). Back-to-back frames are contiguous.
- o_busy = (state != IDLE) || !empty. It is combinational from registers.
- i_data is sampled only on the accepting edge. Changes while o_ready=0 are ignored.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP, lasting MOD clocks. o_tx = XOR of the 8 data bits, XOR PARITY_ODD. Frame is 11*MOD clocks.
- Undefined: no parity state, 8N1 only. PARITY_ODD is unused.

Decomposition:
- Package uart_pkg holds:
  - the TX state enum type;
  - a function computing MOD from F and BAUD (shared with the receiver);
  - the data width constant 8.
- Sub-module uart_tx_fifo: synchronous FIFO, parameter DEPTH. Ports: push/data_in/full, pop/data_out/empty, with show-ahead data_out.
- Baud counting stays inline in uart_tx.

Test Plan:
All scenarios use F=1000000, BAUD=100000 (MOD=10), DEPTH=4.
- Single byte 0x55 pushed at idle -> o_tx low 1 cycle after accept for 10 clocks, then 1,0,1,0,1,0,1,0 (10 clocks each), then high 10 clocks. o_busy drops after 100 clocks.
- Five bytes 0x01..0x05 pushed on consecutive cycles -> all 5 accepted (byte 0 popped immediately). o_ready low after the 5th. A 6th is stalled until byte 1 is popped at the end of frame 0. Frames are contiguous, 500 clocks total, in order.
- Simultaneous push and pop with count=DEPTH-1 -> count unchanged, o_ready stays 1, no data loss.
- i_rst asserted mid-DATA of 0xA3 with 2 bytes queued -> o_tx=1 after the reset edge, o_busy=0, FIFO empty. The next pushed byte 0x3C is sent as a clean complete frame.
- With UART_TX_PARITY_EN, PARITY_ODD=0: byte 0x55 -> parity bit 0, frame 110 clocks. Byte 0x07 -> parity bit 1. With PARITY_ODD=1 both parity bits invert.
- Loopback to the receiver at the same F/BAUD, 256 random bytes -> all received bytes match in order.
